opfetch_stage: RTL and testbench

Register-read/operand-fetch pipeline stage of the 16-bit six-stage pipeline, placed directly upstream of the execute stage and downstream of decode. It selects each source operand from the register file or from the data-dependency forwarding bus (`data_dep_sig1/2`, `data_frm_dh`) and latches the instruction into the RR/EX pipeline register. It also inserts load-use bubbles and honours downstream stall and flush requests.

---
 rtl/opfetch_stage.sv | 134 +++++++++++++
 tb/tb_opfetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opfetch_stage.sv
// opfetch_stage: register-read / operand-fetch stage of the 16-bit pipeline.
// Selects each operand from the register file or the forwarding bus, latches
// the instruction into the RR/EX register, inserts load-use bubbles and obeys
// downstream stall and flush.
// Optional build macro: OPF_STALL_CNT_EN adds a saturating load-use bubble
// counter on output stall_cnt.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_RUN    | normal flow, RR/EX holds a real instruction or a flush bubble
// ST_BUBBLE | RR/EX holds a load-use bubble; decode is re-presenting the consumer
module opfetch_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [4:0]  func,
    input  logic [2:0]  read_a1,
    input  logic [2:0]  read_a2,
    input  logic [2:0]  rf_write_address,
    input  logic [15:0] rf_rd1,
    input  logic [15:0] rf_rd2,
    input  logic        data_dep_sig1,
    input  logic        data_dep_sig2,
    input  logic [15:0] data_frm_dh,
    input  logic        stall_in,
    input  logic        flush,
    output logic        ex_valid,
    output logic [4:0]  ex_func,
    output logic [15:0] ex_opa,
    output logic [15:0] ex_opb,
    output logic [2:0]  ex_wr_addr,
    output logic        stall_out,
    output logic        bubble_q
`ifdef OPF_STALL_CNT_EN
   ,output logic [15:0] stall_cnt
`endif
);

    localparam logic [4:0] LW_FUNC = 5'd15;
    localparam logic [4:0] SW_FUNC = 5'd16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  ex_func_q, ex_func_d;
    logic [15:0] ex_opa_q, ex_opa_d;
    logic [15:0] ex_opb_q, ex_opb_d;
    logic [2:0]  ex_wr_addr_q, ex_wr_addr_d;
    logic        reads_regs;
    logic        lu;

    // Load-use hazard: a load in RR/EX whose destination feeds the decode slot
    always_comb begin
        reads_regs = ((func >= 5'd1) && (func <= 5'd14)) || (func == SW_FUNC) || (func == LW_FUNC);
        lu = ex_valid_q && (ex_func_q == LW_FUNC) && valid_in && reads_regs &&
             ((ex_wr_addr_q == read_a1) || ((func != LW_FUNC) && (ex_wr_addr_q == read_a2)));
        stall_out = stall_in | (lu & ~flush);
    end

    // Next RR/EX contents and state: flush > stall_in > load-use > normal
    always_comb begin
        state_d      = state_q;
        ex_valid_d   = ex_valid_q;
        ex_func_d    = ex_func_q;
        ex_opa_d     = ex_opa_q;
        ex_opb_d     = ex_opb_q;
        ex_wr_addr_d = ex_wr_addr_q;
        if (flush || (!stall_in && lu)) begin
            ex_valid_d   = 1'b0;
            ex_func_d    = 5'd0;
            ex_opa_d     = 16'd0;
            ex_opb_d     = 16'd0;
            ex_wr_addr_d = 3'd0;
            state_d      = flush ? ST_RUN : ST_BUBBLE;
        end else if (!stall_in) begin
            ex_valid_d   = valid_in;
            ex_func_d    = valid_in ? func : 5'd0;
            ex_opa_d     = data_dep_sig1 ? data_frm_dh : rf_rd1;
            ex_opb_d     = data_dep_sig2 ? data_frm_dh : rf_rd2;
            ex_wr_addr_d = rf_write_address;
            state_d      = ST_RUN;
        end
    end

    // RR/EX pipeline register and state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            ex_valid_q   <= 1'b0;
            ex_func_q    <= 5'd0;
            ex_opa_q     <= 16'd0;
            ex_opb_q     <= 16'd0;
            ex_wr_addr_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            ex_valid_q   <= ex_valid_d;
            ex_func_q    <= ex_func_d;
            ex_opa_q     <= ex_opa_d;
            ex_opb_q     <= ex_opb_d;
            ex_wr_addr_q <= ex_wr_addr_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_func    = ex_func_q;
    assign ex_opa     = ex_opa_q;
    assign ex_opb     = ex_opb_q;
    assign ex_wr_addr = ex_wr_addr_q;
    assign bubble_q   = (state_q == ST_BUBBLE);

`ifdef OPF_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count load-use bubbles actually loaded; saturate, survive flush
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && !stall_in && lu && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Bubble counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= 16'd0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_opfetch_stage.sv
// Bench for opfetch_stage: a fixed vector table with hand-derived expectations,
// short hand-written corner sequences, then random stimulus against a
// behavioural model of the RR/EX slot.
module tb_opfetch_stage;

    localparam logic [4:0] LW  = 5'd15;
    localparam logic [4:0] SW  = 5'd16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [4:0]  func;
    logic [2:0]  read_a1, read_a2, rf_write_address;
    logic [15:0] rf_rd1, rf_rd2, data_frm_dh;
    logic        data_dep_sig1, data_dep_sig2, stall_in, flush;
    logic        ex_valid, stall_out, bubble_q;
    logic [4:0]  ex_func;
    logic [15:0] ex_opa, ex_opb;
    logic [2:0]  ex_wr_addr;
`ifdef OPF_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    opfetch_stage dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .func(func),
        .read_a1(read_a1), .read_a2(read_a2), .rf_write_address(rf_write_address),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .data_dep_sig1(data_dep_sig1),
        .data_dep_sig2(data_dep_sig2), .data_frm_dh(data_frm_dh),
        .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_func(ex_func),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_wr_addr(ex_wr_addr),
        .stall_out(stall_out), .bubble_q(bubble_q)
`ifdef OPF_STALL_CNT_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  func;
        logic [2:0]  a1, a2, wa;
        logic [15:0] rd1, rd2;
        logic        dep1, dep2;
        logic [15:0] dh;
        logic        stall, flush;
    } in_t;

    typedef struct packed {
        logic        so;
        logic        valid;
        logic [4:0]  func;
        logic [15:0] opa, opb;
        logic [2:0]  wr;
        logic        bub;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model of the RR/EX slot
    logic        m_valid, m_bub;
    logic [4:0]  m_func;
    logic [15:0] m_opa, m_opb, m_cnt;
    logic [2:0]  m_wr;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk_in(input logic v, input logic [4:0] f, input logic [2:0] a1,
                                  input logic [2:0] a2, input logic [2:0] wa,
                                  input logic [15:0] r1, input logic [15:0] r2,
                                  input logic d1, input logic d2, input logic [15:0] dh,
                                  input logic st, input logic fl);
        in_t x;
        x.valid = v; x.func = f; x.a1 = a1; x.a2 = a2; x.wa = wa; x.rd1 = r1; x.rd2 = r2;
        x.dep1 = d1; x.dep2 = d2; x.dh = dh; x.stall = st; x.flush = fl;
        return x;
    endfunction

    function automatic exp_t mk_ex(input logic so, input logic v, input logic [4:0] f,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] w, input logic bub);
        exp_t e;
        e.so = so; e.valid = v; e.func = f; e.opa = a; e.opb = b; e.wr = w; e.bub = bub;
        return e;
    endfunction

    function automatic logic model_lu(input in_t v);
        logic consumer;
        logic hit;
        consumer = (v.func != 5'd0 && v.func <= 5'd14) || v.func == LW || v.func == SW;
        hit = (m_wr == v.a1) || (v.func != LW && m_wr == v.a2);
        return m_valid && m_func == LW && v.valid && consumer && hit;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_func = 0; m_opa = 0; m_opb = 0; m_wr = 0; m_bub = 0; m_cnt = 0;
    endtask

    task automatic model_clock(input in_t v);
        logic lu;
        lu = model_lu(v);
        if (v.flush) begin
            m_valid = 0; m_func = 0; m_opa = 0; m_opb = 0; m_wr = 0; m_bub = 0;
        end else if (v.stall) begin
        end else if (lu) begin
            m_valid = 0; m_func = 0; m_opa = 0; m_opb = 0; m_wr = 0; m_bub = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = v.valid;
            m_func  = v.valid ? v.func : 5'd0;
            m_opa   = v.dep1 ? v.dh : v.rd1;
            m_opb   = v.dep2 ? v.dh : v.rd2;
            m_wr    = v.wa;
            m_bub   = 0;
        end
    endtask

    task automatic drive(input in_t v);
        valid_in = v.valid; func = v.func; read_a1 = v.a1; read_a2 = v.a2;
        rf_write_address = v.wa; rf_rd1 = v.rd1; rf_rd2 = v.rd2;
        data_dep_sig1 = v.dep1; data_dep_sig2 = v.dep2; data_frm_dh = v.dh;
        stall_in = v.stall; flush = v.flush;
    endtask

    task automatic chk_cnt();
`ifdef OPF_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    task automatic chk_regs(input exp_t e);
        chk("ex_valid", 16'(ex_valid), 16'(e.valid));
        chk("ex_func", 16'(ex_func), 16'(e.func));
        chk("ex_opa", ex_opa, e.opa);
        chk("ex_opb", ex_opb, e.opb);
        chk("ex_wr_addr", 16'(ex_wr_addr), 16'(e.wr));
        chk("bubble_q", 16'(bubble_q), 16'(e.bub));
    endtask

    function automatic exp_t model_exp(input logic so);
        return mk_ex(so, m_valid, m_func, m_opa, m_opb, m_wr, m_bub);
    endfunction

    // called at a negedge; returns at the next negedge
    task automatic step_model(input in_t v);
        logic so;
        drive(v);
        #1;
        so = v.stall | (model_lu(v) & ~v.flush);
        chk("stall_out", 16'(stall_out), 16'(so));
        @(posedge clk);
        model_clock(v);
        #1;
        chk_regs(model_exp(1'b0));
        chk_cnt();
        @(negedge clk);
    endtask

    task automatic step_table(input vec_t t, input int idx);
        drive(t.in);
        #1;
        chk($sformatf("tbl%0d stall_out", idx), 16'(stall_out), 16'(t.ex.so));
        @(posedge clk);
        model_clock(t.in);
        #1;
        chk_regs(t.ex);
        chk_cnt();
        @(negedge clk);
    endtask

    function automatic in_t rnd_in();
        in_t x;
        int r;
        r = int'($urandom_range(0, 9));
        x.valid = ($urandom_range(0, 9) != 0);
        if (r < 4)      x.func = LW;
        else if (r < 8) x.func = 5'($urandom_range(1, 14));
        else if (r < 9) x.func = SW;
        else            x.func = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(17, 31));
        x.a1 = 3'($urandom_range(0, 3));
        x.a2 = 3'($urandom_range(0, 3));
        x.wa = 3'($urandom_range(0, 3));
        x.rd1 = 16'($urandom); x.rd2 = 16'($urandom); x.dh = 16'($urandom);
        x.dep1 = 1'($urandom); x.dep2 = 1'($urandom);
        x.stall = ($urandom_range(0, 5) == 0);
        x.flush = ($urandom_range(0, 7) == 0);
        return x;
    endfunction

    vec_t tbl [10];
    in_t  ld, add_c;

    initial begin
        tbl[0] = '{mk_in(1,5'd1,3'd1,3'd2,3'd5,16'h1111,16'h2222,1,0,16'hABCD,0,0),
                   mk_ex(0,1,5'd1,16'hABCD,16'h2222,3'd5,0)};
        tbl[1] = '{mk_in(1,5'd1,3'd1,3'd2,3'd5,16'h1111,16'h2222,1,1,16'hABCD,0,0),
                   mk_ex(0,1,5'd1,16'hABCD,16'hABCD,3'd5,0)};
        tbl[2] = '{mk_in(1,LW,3'd1,3'd3,3'd3,16'h0010,16'h0020,0,0,16'h0000,0,0),
                   mk_ex(0,1,LW,16'h0010,16'h0020,3'd3,0)};
        tbl[3] = '{mk_in(1,5'd1,3'd2,3'd3,3'd6,16'h0100,16'h0200,0,0,16'h0000,0,0),
                   mk_ex(1,0,5'd0,16'h0000,16'h0000,3'd0,1)};
        tbl[4] = '{mk_in(1,5'd1,3'd2,3'd3,3'd6,16'h0100,16'h0200,0,1,16'h5555,0,0),
                   mk_ex(0,1,5'd1,16'h0100,16'h5555,3'd6,0)};
        tbl[5] = '{mk_in(1,LW,3'd7,3'd0,3'd3,16'h0001,16'h0002,0,0,16'h0000,0,0),
                   mk_ex(0,1,LW,16'h0001,16'h0002,3'd3,0)};
        tbl[6] = '{mk_in(1,LW,3'd4,3'd3,3'd2,16'hAAAA,16'hBBBB,0,0,16'h0000,0,0),
                   mk_ex(0,1,LW,16'hAAAA,16'hBBBB,3'd2,0)};
        tbl[7] = '{mk_in(1,SW,3'd2,3'd0,3'd0,16'h1234,16'h5678,0,0,16'h0000,0,1),
                   mk_ex(0,0,5'd0,16'h0000,16'h0000,3'd0,0)};
        tbl[8] = '{mk_in(0,5'd7,3'd1,3'd1,3'd4,16'h0F0F,16'hF0F0,0,0,16'h0000,0,0),
                   mk_ex(0,0,5'd0,16'h0F0F,16'hF0F0,3'd4,0)};
        tbl[9] = '{mk_in(1,5'd2,3'd4,3'd4,3'd1,16'h7777,16'h8888,0,0,16'h0000,1,0),
                   mk_ex(1,0,5'd0,16'h0F0F,16'hF0F0,3'd4,0)};

        // reset held 3 cycles with random inputs
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(rnd_in());
            @(negedge clk);
            chk_regs(mk_ex(0,0,5'd0,16'h0,16'h0,3'd0,0));
            chk("rst stall_out", 16'(stall_out), 16'(stall_in));
            chk_cnt();
        end
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) step_table(tbl[i], i);

        // stall_in held 4 cycles mid-stream
        step_model(mk_in(1,5'd3,3'd1,3'd2,3'd4,16'h1357,16'h2468,0,0,16'h0,0,0));
        for (int i = 0; i < 4; i++) step_model(mk_in(1,5'd4,3'd0,3'd0,3'd5,16'(i),16'h9999,0,0,16'h0,1,0));
        step_model(mk_in(1,5'd4,3'd0,3'd0,3'd5,16'hCAFE,16'h9999,0,0,16'h0,0,0));

        // stall_in coincident with load-use: bubble deferred until stall drops
        ld    = mk_in(1,LW,3'd0,3'd0,3'd5,16'h4000,16'h0,0,0,16'h0,0,0);
        add_c = mk_in(1,5'd1,3'd5,3'd1,3'd6,16'h0101,16'h0202,0,0,16'h0,1,0);
        step_model(ld);
        step_model(add_c);
        step_model(add_c);
        add_c.stall = 1'b0;
        step_model(add_c);
        chk("deferred bubble", 16'(bubble_q), 16'd1);
        add_c.dep1 = 1'b1; add_c.dh = 16'hD00D;
        step_model(add_c);

        // asynchronous reset while a load-use bubble is pending
        ld.wa = 3'd1;
        step_model(ld);
        add_c = mk_in(1,5'd1,3'd1,3'd2,3'd0,16'h1,16'h2,0,0,16'h0,0,0);
        step_model(add_c);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_regs(mk_ex(0,0,5'd0,16'h0,16'h0,3'd0,0));
        chk_cnt();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 600; i++) step_model(rnd_in());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
